// File: rtl/c3lib_ckdiv_chk_pkg.sv
// Shared types and helpers for the divided-clock checker.
// Holds the checker FSM state encoding and the tolerance compare.
package c3lib_ckdiv_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACQ,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  // True when |meas - target| <= tol.
  function automatic logic within_tol(input int meas, input int target, input int tol);
    int diff;
    diff = meas - target;
    if (diff < 0) diff = -diff;
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/c3lib_ckdiv_chk_edge.sv
// Synchronizer for the asynchronous divided clock plus rising-edge detect.
// rise_p is high for the single cycle in which the synchronized level first reads 1.
module c3lib_ckdiv_chk_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic div_clk_in,
  output logic sync,
  output logic rise_p
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_d_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_reg   <= '0;
      sync_d_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], div_clk_in};
      sync_d_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync   = sync_reg[SYNC_STAGES-1];
  assign rise_p = sync & ~sync_d_reg;

endmodule

// File: rtl/c3lib_ckdiv_chk_ctn.sv
// Divided-clock checker: measures period and high time of div_clk_in in clk_in
// cycles, acquires lock after LOCK_CNT good periods and flags loss of lock.
module c3lib_ckdiv_chk_ctn
  import c3lib_ckdiv_chk_pkg::*;
#(
  parameter int DIV_RATIO   = 8,
  parameter int TOL         = 0,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             div_clk_in,
  input  logic             err_clr,
  output logic             lock,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] high_meas
);

  localparam int GC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(2 * DIV_RATIO);
  localparam logic [GC_W-1:0]  GC_LAST     = GC_W'(LOCK_CNT - 1);

  logic             sync;
  logic             rise_p;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] hcnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] high_reg;
  logic [GC_W-1:0]  good_cnt_reg, good_cnt_next;
  state_t           state_reg, state_next;
  logic             err_sticky_reg;
  logic             good;
  logic             timeout;

  c3lib_ckdiv_chk_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk_in    (clk_in),
    .rst       (rst),
    .div_clk_in(div_clk_in),
    .sync      (sync),
    .rise_p    (rise_p)
  );

  // Judged on the values being captured this cycle, not the previous capture.
  assign good    = within_tol(int'(cnt_reg), DIV_RATIO, TOL) &&
                   within_tol(int'(hcnt_reg), DIV_RATIO / 2, TOL);
  assign timeout = (cnt_reg == TIMEOUT_CNT) && !rise_p;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_reg    <= '0;
      hcnt_reg   <= '0;
      period_reg <= '0;
      high_reg   <= '0;
    end else if (rise_p) begin
      // The rise cycle itself is the first cycle of both the new period and its high phase.
      cnt_reg  <= CNT_W'(1);
      hcnt_reg <= CNT_W'(1);
      if (state_reg != ST_IDLE) begin
        period_reg <= cnt_reg;
        high_reg   <= hcnt_reg;
      end
    end else begin
      if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
      if (sync && hcnt_reg != CNT_MAX) hcnt_reg <= hcnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      good_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    if (!chk_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_SYNC;
        ST_SYNC: begin
          if (rise_p) begin
            state_next    = ST_ACQ;
            good_cnt_next = '0;
          end
        end
        ST_ACQ: begin
          if (rise_p) begin
            if (!good) begin
              good_cnt_next = '0;
            end else if (good_cnt_reg == GC_LAST) begin
              state_next    = ST_LOCKED;
              good_cnt_next = '0;
            end else begin
              good_cnt_next = good_cnt_reg + 1'b1;
            end
          end else if (timeout) begin
            state_next = ST_SYNC;
          end
        end
        ST_LOCKED: begin
          if ((rise_p && !good) || timeout) state_next = ST_FAIL;
        end
        ST_FAIL: state_next = ST_SYNC;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Set has priority over clear so a coincident err_clr cannot hide a fresh error.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      err_sticky_reg <= 1'b0;
    end else if (err_pulse) begin
      err_sticky_reg <= 1'b1;
    end else if (err_clr) begin
      err_sticky_reg <= 1'b0;
    end
  end

  assign lock        = (state_reg == ST_LOCKED);
  assign err_pulse   = (state_reg == ST_FAIL);
  assign err_sticky  = err_sticky_reg;
  assign period_meas = period_reg;
  assign high_meas   = high_reg;

endmodule

// File: tb/tb_c3lib_ckdiv_chk_ctn.sv
// Directed bench for c3lib_ckdiv_chk_ctn: table of div_clk_in periods with
// hand-computed captures and lock status, plus sequences for timeout, clear and reset.
module tb_c3lib_ckdiv_chk_ctn;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       chk_en = 1'b0;
  logic       div_clk_in = 1'b0;
  logic       err_clr = 1'b0;

  logic       lock0, err_pulse0, err_sticky0;
  logic [7:0] period_meas0, high_meas0;
  logic       lock1, err_pulse1, err_sticky1;
  logic [7:0] period_meas1, high_meas1;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  typedef struct {
    int per;
    int hi;
    int exp_per;
    int exp_hi;
    int exp_lock;
    int exp_sticky;
    int exp_pulses;
  } vec_t;

  vec_t vecs[12];

  always #5 clk_in = ~clk_in;

  c3lib_ckdiv_chk_ctn dut0 (
    .clk_in     (clk_in),
    .rst        (rst),
    .chk_en     (chk_en),
    .div_clk_in (div_clk_in),
    .err_clr    (err_clr),
    .lock       (lock0),
    .err_pulse  (err_pulse0),
    .err_sticky (err_sticky0),
    .period_meas(period_meas0),
    .high_meas  (high_meas0)
  );

  c3lib_ckdiv_chk_ctn #(.TOL(1)) dut1 (
    .clk_in     (clk_in),
    .rst        (rst),
    .chk_en     (chk_en),
    .div_clk_in (div_clk_in),
    .err_clr    (err_clr),
    .lock       (lock1),
    .err_pulse  (err_pulse1),
    .err_sticky (err_sticky1),
    .period_meas(period_meas1),
    .high_meas  (high_meas1)
  );

  always @(posedge clk_in) if (err_pulse0 === 1'b1) pulse_cnt++;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_period(input int p, input int h);
    div_clk_in = 1'b1;
    repeat (h) tick();
    div_clk_in = 1'b0;
    repeat (p - h) tick();
  endtask

  initial begin
    int n;
    // per, hi, captured period/high at end of row (previous row), lock, sticky, pulses
    vecs[0]  = '{8, 4, -1, -1, 0, 0, 0};
    vecs[1]  = '{8, 4,  8,  4, 0, 0, 0};
    vecs[2]  = '{8, 4,  8,  4, 0, 0, 0};
    vecs[3]  = '{8, 4,  8,  4, 0, 0, 0};
    vecs[4]  = '{8, 4,  8,  4, 1, 0, 0};
    vecs[5]  = '{9, 4,  8,  4, 1, 0, 0};
    vecs[6]  = '{8, 4,  9,  4, 0, 1, 1};
    vecs[7]  = '{8, 4,  8,  4, 0, 1, 1};
    vecs[8]  = '{8, 4,  8,  4, 0, 1, 1};
    vecs[9]  = '{8, 4,  8,  4, 0, 1, 1};
    vecs[10] = '{8, 4,  8,  4, 0, 1, 1};
    vecs[11] = '{8, 4,  8,  4, 1, 1, 1};

    repeat (3) tick();
    chk("reset lock", lock0, 0);
    chk("reset err_pulse", err_pulse0, 0);
    chk("reset err_sticky", err_sticky0, 0);
    chk("reset period_meas", period_meas0, 0);
    chk("reset high_meas", high_meas0, 0);

    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      drive_period(vecs[i].per, vecs[i].hi);
      if (vecs[i].exp_per >= 0) begin
        chk($sformatf("row%0d period_meas", i), period_meas0, vecs[i].exp_per);
        chk($sformatf("row%0d high_meas", i), high_meas0, vecs[i].exp_hi);
      end
      chk($sformatf("row%0d lock", i), lock0, vecs[i].exp_lock);
      chk($sformatf("row%0d err_sticky", i), err_sticky0, vecs[i].exp_sticky);
      chk($sformatf("row%0d err_pulses", i), pulse_cnt, vecs[i].exp_pulses);
      $display("row %0d per=%0d hi=%0d -> period_meas=%0d high_meas=%0d lock=%0d sticky=%0d",
               i, vecs[i].per, vecs[i].hi, period_meas0, high_meas0, lock0, err_sticky0);
    end

    // err_clr on its own clears the sticky flag.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr alone err_sticky", err_sticky0, 0);

    // Hold div_clk_in low while locked: counter reaches 2*DIV_RATIO then loses lock.
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (err_pulse0 === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("timeout cycles to err_pulse", n, 10);
    chk("timeout lock", lock0, 0);
    chk("timeout period_meas held", period_meas0, 8);
    chk("timeout high_meas held", high_meas0, 4);
    $display("timeout: err_pulse after %0d cycles", n);

    // err_clr coincident with err_pulse: set wins.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr+pulse err_sticky", err_sticky0, 1);
    chk("err_pulse one cycle", err_pulse0, 0);
    chk("timeout pulse count", pulse_cnt, 2);

    // FAIL -> SYNC, then relock after five good edges.
    for (int i = 0; i < 5; i++) drive_period(8, 4);
    chk("relock after timeout", lock0, 1);
    $display("relock after timeout: lock=%0d", lock0);

    // Drop chk_en while locked; measurements hold in IDLE.
    chk_en = 1'b0;
    tick();
    chk("chk_en drop lock", lock0, 0);
    drive_period(12, 6);
    drive_period(12, 6);
    chk("idle period_meas held", period_meas0, 8);
    chk("idle high_meas held", high_meas0, 4);
    chk("idle err_sticky held", err_sticky0, 1);
    $display("chk_en=0: lock=%0d period_meas=%0d", lock0, period_meas0);

    // Relock, then reset mid-period.
    chk_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) drive_period(8, 4);
    chk("relock before reset", lock0, 1);
    div_clk_in = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst lock", lock0, 0);
    chk("midrst err_pulse", err_pulse0, 0);
    chk("midrst err_sticky", err_sticky0, 0);
    chk("midrst period_meas", period_meas0, 0);
    chk("midrst high_meas", high_meas0, 0);
    $display("mid-period reset: lock=%0d sticky=%0d period=%0d", lock0, err_sticky0, period_meas0);
    div_clk_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 3/8 duty: no lock at TOL=0, lock at TOL=1.
    for (int i = 0; i < 5; i++) drive_period(8, 3);
    chk("duty38 tol0 lock", lock0, 0);
    chk("duty38 tol0 err_sticky", err_sticky0, 0);
    chk("duty38 tol0 high_meas", high_meas0, 3);
    chk("duty38 tol0 period_meas", period_meas0, 8);
    chk("duty38 tol0 pulses", pulse_cnt, 2);
    chk("duty38 tol1 lock", lock1, 1);
    chk("duty38 tol1 high_meas", high_meas1, 3);
    chk("duty38 tol1 err_sticky", err_sticky1, 0);
    $display("duty 3/8: tol0 lock=%0d tol1 lock=%0d", lock0, lock1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
